apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- APB bridge and arbiter. Shares a single APB master port between N_REQ local requesters.
- Grants one requester at a time using round-robin arbitration.
- Sequences the APB transfer through IDLE -> SETUP -> ACCESS and waits for PREADY.
- Returns read data, a completion pulse and a timeout error flag to the granted requester. Sits between local command sources and the APB slave peripherals.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  input  1  APB clock
- PRESETn  input  1  synchronous active-high reset
- req  input  N_REQ  per-requester transfer request, level; held until done
- req_write  input  N_REQ  per-requester direction, 1=write
- req_addr  input  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  input  N_REQ*DW  packed write data, same packing
- gnt  output  N_REQ  one-hot, current owner, held SETUP..ACCESS
- done  output  N_REQ  one-cycle completion pulse to owner
- err  output  1  valid with done; 1 = transfer aborted by timeout
- rdata  output  DW  read data, valid with done on reads
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PWRITE  output  1  APB direction
- PADDR  output  AW  APB address
- PWDATA  output  DW  APB write data
- PRDATA  input  DW  APB read data
- PREADY  input  1  APB ready

Behaviour:
- Single clock PCLK. Reset PRESETn is synchronous and active-high. All outputs registered.
- Reset state: FSM=IDLE, rr_ptr=0, all outputs 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req bit is set, pick the winner by round-robin: search starts at rr_ptr, first set bit wins.
  - Next cycle: SETUP with gnt=onehot(winner), PSEL=1, PENABLE=0.
  - PADDR, PWRITE and PWDATA are latched from the winner's inputs. PWDATA is 0 on reads.
- SETUP: lasts exactly 1 cycle, then ACCESS with PENABLE=1. PADDR, PWRITE and PWDATA stay stable.
- ACCESS:
  - Wait counter starts at 0 and increments each cycle with PREADY=0.
  - PREADY=1: next cycle done[winner]=1 and err=0. rdata=PRDATA sampled at that edge on reads, 0 on writes. PSEL, PENABLE and gnt clear. rr_ptr=(winner+1) mod N_REQ. FSM -> IDLE.
  - TIMEOUT!=0 and counter reaches TIMEOUT with PREADY still 0: abort. Next cycle done[winner]=1, err=1, rdata=0, PSEL and PENABLE clear, rr_ptr advances, FSM -> IDLE.
- Minimum transfer: 3 cycles from arbitration to done (IDLE, SETUP, ACCESS with PREADY=1).
- A new arbitration may start the cycle done is high. Requesters deassert req on done. A req still high during done is the requester's responsibility; the arbiter samples requests only in IDLE.
- req changes during SETUP/ACCESS are ignored; addr/data/dir are latched.
- A requester dropping req mid-transfer does not abort the transfer; done still pulses.
- Only one bit of done and gnt is ever high. done and gnt are never high in the same cycle.
- Reset asserted in any state: next edge forces IDLE and clears all outputs, including any in-flight PSEL/PENABLE. No done is generated for the killed transfer.
- rr_ptr wrap: at winner=N_REQ-1, rr_ptr returns to 0.

Decomposition:
- Shared package apb_pkg:
  - State enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10).
  - APB phase constants.
  - Default AW/DW.
- Sub-module rr_arbiter: combinational round-robin, inputs req and rr_ptr, outputs one-hot winner and winner index.
- FSM, timeout counter and APB registers stay in apb_master_arbiter.

Test Plan:
- Single write: req=0001, write, addr=0x10, wdata=0xDEADBEEF; slave PREADY one cycle after PENABLE -> gnt[0] for SETUP+2 ACCESS cycles; PSEL/PENABLE 10,11,11; done[0] 4 cycles after req; err=0.
- Single read: req=0100, addr=0x20; PRDATA=0xCAFEF00D while PREADY=1 -> done[2]=1, rdata=0xCAFEF00D, PWRITE=0 throughout.
- Round-robin: req=1111 held and reissued after each done -> grant order 0,1,2,3,0; never twice in a row while others are pending.
- Contention after wrap: rr_ptr=3, req=1001 -> requester 3 granted first, then 0; rr_ptr ends at 1.
- Timeout: TIMEOUT=4, PREADY tied 0 -> PSEL stays high through 4 ACCESS cycles, then done=1, err=1, rdata=0; next request serviced normally.
- Reset mid-ACCESS: PRESETn=1 for one cycle during ACCESS -> next cycle PSEL=PENABLE=0, gnt=0, no done pulse; rr_ptr=0.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master arbiter:
//   apb_state_e : transfer FSM states (IDLE, SETUP, ACCESS)
//   PH_*        : {PSEL, PENABLE} encodings for each APB phase
//   APB_AW/DW   : default address and data widths
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // {PSEL, PENABLE} for each phase of an APB transfer
    localparam logic [1:0] PH_IDLE   = 2'b00;
    localparam logic [1:0] PH_SETUP  = 2'b10;
    localparam logic [1:0] PH_ACCESS = 2'b11;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search starts at rr_ptr and wraps;
// the first set request bit wins.
// Ports:
//   req     in  N_REQ  request vector
//   rr_ptr  in  IW     index where the search begins
//   win_oh  out N_REQ  one-hot winner (all zero when no request)
//   win_idx out IW     winner index
//   win_vld out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [IW-1:0]    win_idx,
    output logic             win_vld
);

    logic [IW-1:0] pos;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = IW'((int'(rr_ptr) + k) % N_REQ);
            if (!win_vld && req[pos]) begin
                win_vld     = 1'b1;
                win_idx     = pos;
                win_oh[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB master port between N_REQ local requesters. A round-robin
// winner is chosen in IDLE, its command is latched, and the transfer runs
// SETUP -> ACCESS until PREADY or until TIMEOUT wait cycles expire.
// Ports:
//   PCLK, PRESETn             clock, synchronous active-high reset
//   req/req_write             per-requester request level and direction
//   req_addr/req_wdata        packed command fields, requester i at [i*W +: W]
//   gnt                       one-hot owner during SETUP..ACCESS
//   done/err/rdata            completion pulse, timeout flag, read data
//   PSEL..PWDATA, PRDATA,     APB master interface
//   PREADY
// -----------------------------------------------------------------------------
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    req_write,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                err,
    output logic [DW-1:0]       rdata,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [AW-1:0]       PADDR,
    output logic [DW-1:0]       PWDATA,
    input  logic [DW-1:0]       PRDATA,
    input  logic                PREADY
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    apb_state_e       state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             err_q, err_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic             psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [AW-1:0]    paddr_q, paddr_d;
    logic [DW-1:0]    pwdata_q, pwdata_d;

    logic [N_REQ-1:0] arb_oh;
    logic [IW-1:0]    arb_idx;
    logic             arb_vld;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx),
        .win_vld (arb_vld)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    state_d             = SETUP;
                    gnt_d               = arb_oh;
                    win_d               = arb_idx;
                    {psel_d, penable_d} = PH_SETUP;
                    pwrite_d            = req_write[arb_idx];
                    paddr_d             = req_addr[int'(arb_idx)*AW +: AW];
                    pwdata_d            = req_write[arb_idx] ?
                                          req_wdata[int'(arb_idx)*DW +: DW] : '0;
                end
            end
            SETUP: begin
                state_d             = ACCESS;
                {psel_d, penable_d} = PH_ACCESS;
                cnt_d               = '0;
            end
            ACCESS: begin
                // Completion and timeout abort share the same wind-down; only
                // err and rdata differ.
                if (PREADY || (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d             = IDLE;
                    gnt_d               = '0;
                    done_d              = gnt_q;
                    {psel_d, penable_d} = PH_IDLE;
                    rr_ptr_d            = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
                    err_d               = !PREADY;
                    rdata_d             = (PREADY && !pwrite_q) ? PRDATA : '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            win_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Drives randomized requester commands and a slave with a chosen number of
// wait states. Each transfer is predicted from the arbitration rules (circular
// search from the round-robin pointer) and the transfer timing (SETUP, then
// ACCESS until ready or until the wait limit), then compared with what the
// DUT did.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn;
    logic [N-1:0]    req, req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA, PRDATA;
    logic            PREADY;

    apb_master_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .err(err), .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;

    logic [31:0] tb_addr[N];
    logic [31:0] tb_wdata[N];
    logic        tb_write[N];

    // observations of the most recent transfer
    logic [3:0]  o_gnt, o_done;
    logic        o_err, o_pwrite, o_bad, o_tmo;
    logic [31:0] o_rdata, o_paddr, o_pwdata;
    int          o_ks, o_kd;
    logic [1:0]  o_ph[8];

    logic [123:0] g, e;

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        tb_write[i] = wr;
        tb_addr[i]  = a;
        tb_wdata[i] = d;
        req_write[i] = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'($urandom), $urandom, $urandom);
    endtask

    // circular search from p, first set bit wins
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Runs one transfer: asserts reqs, plays a slave that raises PREADY after
    // 'waits' ACCESS cycles, records what the DUT did. Starts and ends on a
    // falling edge with the DUT able to arbitrate on the next rising edge.
    task automatic run_xfer(input logic [3:0] reqs, input int waits, input logic [31:0] rd_val, input bit drop_mid);
        int acc;
        acc = 0; o_ks = 0; o_kd = 0; o_bad = 1'b0; o_tmo = 1'b1;
        o_gnt = '0; o_done = '0; o_err = 1'b0; o_rdata = '0;
        o_paddr = '0; o_pwrite = 1'b0; o_pwdata = '0;
        for (int i = 0; i < 8; i++) o_ph[i] = 2'b00;
        req = reqs;
        for (int k = 1; k <= 64; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (k < 8) o_ph[k] = {PSEL, PENABLE};
            if ((gnt & done) != 0 || $countones(gnt) > 1 || $countones(done) > 1) o_bad = 1'b1;
            if (PSEL && !PENABLE) begin
                if (o_ks == 0) begin
                    o_ks = k; o_gnt = gnt; o_paddr = PADDR; o_pwrite = PWRITE; o_pwdata = PWDATA;
                end else o_bad = 1'b1;
                PREADY = 1'b0;
                PRDATA = $urandom;
                if (drop_mid) begin
                    req       = '0;
                    req_write = ~req_write;
                    req_addr  = {N{32'($urandom)}};
                    req_wdata = {N{32'($urandom)}};
                end
            end else if (PSEL && PENABLE) begin
                if (o_ks == 0 || gnt !== o_gnt || PADDR !== o_paddr ||
                    PWRITE !== o_pwrite || PWDATA !== o_pwdata) o_bad = 1'b1;
                if (acc == waits) begin
                    PREADY = 1'b1; PRDATA = rd_val;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom;
                end
                acc++;
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
                if (gnt != 0 || PENABLE) o_bad = 1'b1;
            end
            if (done != 0) begin
                o_kd = k; o_done = done; o_err = err; o_rdata = rdata; o_tmo = 1'b0;
                break;
            end
        end
        req    = '0;
        PREADY = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, tb_write[i], tb_addr[i], tb_wdata[i]);
    endtask

    // Predicts the transfer outcome, runs it, and returns both as packed records.
    task automatic go(input logic [3:0] reqs, input int waits, input logic [31:0] rd, input bit drop,
                      output logic [123:0] got, output logic [123:0] exp);
        int w, kd;
        logic e_err;
        logic [31:0] e_rd, e_pwd;
        w     = rr_pick(reqs, m_ptr);
        e_err = (waits >= TMO);
        kd    = e_err ? 2 + TMO : 3 + waits;
        e_rd  = (tb_write[w] || e_err) ? 32'h0 : rd;
        e_pwd = tb_write[w] ? tb_wdata[w] : 32'h0;
        exp   = {4'(1 << w), 4'(1 << w), e_err, e_rd, tb_addr[w], tb_write[w], e_pwd,
                 8'd1, 8'(kd), 1'b0, 1'b0};
        run_xfer(reqs, waits, rd, drop);
        got   = {o_gnt, o_done, o_err, o_rdata, o_paddr, o_pwrite, o_pwdata,
                 8'(o_ks), 8'(o_kd), o_bad, o_tmo};
        m_ptr = (w + 1) % N;
    endtask

    task automatic test_reset();
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        vectors++;
        if ({gnt, done, err, PSEL, PENABLE, PWRITE} !== 12'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl got=%h exp=0", {gnt, done, err, PSEL, PENABLE, PWRITE});
        end
        vectors++;
        if ({rdata, PADDR, PWDATA} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got=%h exp=0", {rdata, PADDR, PWDATA});
        end
        PRESETn = 1'b0;
        m_ptr   = 0;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        go(4'b0001, 1, $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL single_write got=%h exp=%h", g, e); end
        vectors++;
        if ({o_ph[1], o_ph[2], o_ph[3], o_ph[4]} !== 8'b10_11_11_00) begin
            miscompares++;
            $display("FAIL single_write_phases got=%b exp=10111100", {o_ph[1], o_ph[2], o_ph[3], o_ph[4]});
        end
    endtask

    task automatic test_single_read();
        set_req(2, 1'b0, 32'h20, 32'h55AA55AA);
        go(4'b0100, 2, 32'hCAFEF00D, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL single_read got=%h exp=%h", g, e); end
    endtask

    task automatic test_wrap_contention();
        randomize_reqs();
        go(4'b1001, $urandom_range(0, 2), $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL wrap_first got=%h exp=%h", g, e); end
        go(4'b0001, $urandom_range(0, 2), $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL wrap_second got=%h exp=%h", g, e); end
        go(4'b0011, 0, $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL wrap_ptr_after got=%h exp=%h", g, e); end
    endtask

    task automatic test_round_robin();
        logic [3:0] prev;
        prev = 4'b0000;
        for (int n = 0; n < 6; n++) begin
            randomize_reqs();
            go(4'b1111, $urandom_range(0, 2), $urandom, 1'b0, g, e);
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL round_robin[%0d] got=%h exp=%h", n, g, e); end
            vectors++;
            if (o_gnt === prev) begin
                miscompares++;
                $display("FAIL round_robin_repeat[%0d] got=%b exp=not %b", n, o_gnt, prev);
            end
            prev = o_gnt;
        end
    endtask

    task automatic test_timeout();
        set_req(1, 1'b0, 32'h44, 32'h0);
        go(4'b0010, 40, 32'h12345678, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL timeout got=%h exp=%h", g, e); end
        vectors++;
        if ({o_ph[2], o_ph[3], o_ph[4], o_ph[5], o_ph[6]} !== 10'b11_11_11_11_00) begin
            miscompares++;
            $display("FAIL timeout_phases got=%b exp=1111111100", {o_ph[2], o_ph[3], o_ph[4], o_ph[5], o_ph[6]});
        end
        set_req(1, 1'b0, 32'h48, 32'h0);
        go(4'b0010, 1, 32'hA5A5_0001, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL timeout_recover got=%h exp=%h", g, e); end
    endtask

    task automatic test_reset_mid_access();
        logic [3:0] seen;
        randomize_reqs();
        go(4'b0010, 0, $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL pre_reset got=%h exp=%h", g, e); end
        set_req(2, 1'b1, 32'h80, 32'h1234ABCD);
        req = 4'b0100;
        @(posedge PCLK); @(negedge PCLK);
        req = 4'b0000;
        @(posedge PCLK); @(negedge PCLK);
        vectors++;
        if ({PSEL, PENABLE, gnt} !== 6'b11_0100) begin
            miscompares++;
            $display("FAIL mid_access_state got=%b exp=110100", {PSEL, PENABLE, gnt});
        end
        PRESETn = 1'b1;
        @(posedge PCLK); @(negedge PCLK);
        PRESETn = 1'b0;
        vectors++;
        if ({PSEL, PENABLE, gnt, done, err} !== 11'h0) begin
            miscompares++;
            $display("FAIL reset_kill got=%b exp=0", {PSEL, PENABLE, gnt, done, err});
        end
        seen = '0;
        repeat (6) begin
            @(posedge PCLK); @(negedge PCLK);
            seen = seen | done;
        end
        vectors++;
        if (seen !== 4'b0000) begin miscompares++; $display("FAIL reset_no_done got=%b exp=0000", seen); end
        m_ptr = 0;
        randomize_reqs();
        go(4'b1111, 0, $urandom, 1'b0, g, e);
        vectors++;
        if (g !== e) begin miscompares++; $display("FAIL reset_ptr got=%h exp=%h", g, e); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int n = 0; n < 24; n++) begin
            randomize_reqs();
            r = 4'($urandom);
            if (r == 4'b0000) r = 4'(1 << $urandom_range(0, 3));
            go(r, $urandom_range(0, 6), $urandom, 1'($urandom), g, e);
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL random[%0d] got=%h exp=%h", n, g, e); end
        end
    endtask

    initial begin
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PRESETn = 1'b1;
        randomize_reqs();
        test_reset();
        test_single_write();
        test_single_read();
        test_wrap_contention();
        test_round_robin();
        test_timeout();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
